// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - 8N1 UART transmitter with a small write FIFO and fractional baud generator
module uart_tx_fifo #(
    parameter int ClkFrequency  = 24000000,
    parameter int Baud          = 115200,
    parameter int BaudAccWidth  = 16,
    parameter int FifoDepthLog2 = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     TxD_start,
    input  logic [7:0]               TxD_data,
    output logic                     TxD_full,
    output logic                     TxD_overflow,
    output logic                     TxD_busy,
    output logic [FifoDepthLog2:0]   TxD_level,
    output logic                     TxD
);
    localparam int LP_DEPTH = 2 ** FifoDepthLog2;
    localparam logic [FifoDepthLog2:0] LP_FULL_LEVEL = (FifoDepthLog2 + 1)'(LP_DEPTH);
    localparam logic [63:0] LP_INC_WIDE =
        ((64'(Baud) << (BaudAccWidth - 4)) + (64'(ClkFrequency) >> 5)) / (64'(ClkFrequency) >> 4);
    localparam logic [BaudAccWidth:0] LP_INC = LP_INC_WIDE[BaudAccWidth:0];

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        START = 4'd1,
        B0    = 4'd2,
        B1    = 4'd3,
        B2    = 4'd4,
        B3    = 4'd5,
        B4    = 4'd6,
        B5    = 4'd7,
        B6    = 4'd8,
        B7    = 4'd9,
        STOP  = 4'd10
    } state_t;

    logic [7:0]               r_mem [LP_DEPTH];
    logic [FifoDepthLog2-1:0] r_wr_ptr;
    logic [FifoDepthLog2-1:0] r_rd_ptr;
    logic [FifoDepthLog2:0]   r_level;
    logic                     r_overflow;
    logic                     r_busy;
    logic                     r_txd;
    logic [7:0]               r_shift;
    logic [BaudAccWidth:0]    r_acc;
    state_t                   r_state;

    logic                     w_full;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_tick;
    logic                     w_load;
    logic                     w_shift;
    logic                     w_txd_nxt;
    logic [FifoDepthLog2:0]   w_level_nxt;
    state_t                   w_state_nxt;

    // Full is taken from the registered level, so a pop in the same cycle never frees room for a write.
    assign w_full = (r_level == LP_FULL_LEVEL);
    assign w_push = TxD_start && !w_full;
    assign w_tick = r_acc[BaudAccWidth];

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + 1'b1;
        end else if (!w_push && w_pop) begin
            w_level_nxt = r_level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= TxD_start && w_full;
            r_level    <= w_level_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= TxD_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_txd_nxt   = r_txd;
        case (r_state)
            IDLE: begin
                if (r_level != '0) begin
                    w_pop       = 1'b1;
                    w_load      = 1'b1;
                    w_txd_nxt   = 1'b0;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_tick) begin
                    w_txd_nxt   = r_shift[0];
                    w_state_nxt = B0;
                end
            end
            B0, B1, B2, B3, B4, B5, B6: begin
                if (w_tick) begin
                    w_shift     = 1'b1;
                    w_txd_nxt   = r_shift[1];
                    w_state_nxt = state_t'(r_state + 4'd1);
                end
            end
            B7: begin
                if (w_tick) begin
                    w_shift     = 1'b1;
                    w_txd_nxt   = 1'b1;
                    w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (r_level != '0) begin
                        w_pop       = 1'b1;
                        w_load      = 1'b1;
                        w_txd_nxt   = 1'b0;
                        w_state_nxt = START;
                    end else begin
                        w_txd_nxt   = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_txd_nxt   = 1'b1;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Holding the accumulator at zero while idle makes every first start bit a full period.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_txd   <= 1'b1;
            r_shift <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_txd  <= w_txd_nxt;
            r_acc  <= (r_state == IDLE) ? '0 : ({1'b0, r_acc[BaudAccWidth-1:0]} + LP_INC);
            r_busy <= (w_state_nxt != IDLE) || (w_level_nxt != '0);
            if (w_load) begin
                r_shift <= r_mem[r_rd_ptr];
            end else if (w_shift) begin
                r_shift <= {1'b0, r_shift[7:1]};
            end
        end
    end

    assign TxD_full     = w_full;
    assign TxD_overflow = r_overflow;
    assign TxD_busy     = r_busy;
    assign TxD_level    = r_level;
    assign TxD          = r_txd;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo at 1.152 MHz / 115200 baud
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       TxD_start = 1'b0;
    logic [7:0] TxD_data = 8'h00;
    logic       TxD_full;
    logic       TxD_overflow;
    logic       TxD_busy;
    logic [2:0] TxD_level;
    logic       TxD;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] rx_q[$];
    logic       rx_stop_q[$];
    int         rx_gap_q[$];
    logic [7:0] exp_q[$];

    typedef struct {
        logic       start;
        logic [7:0] data;
        int         level;
        int         full;
        int         busy;
        int         ovf;
        int         txd;
    } vec_t;

    vec_t vecs[7];

    uart_tx_fifo #(
        .ClkFrequency (1152000),
        .Baud         (115200),
        .BaudAccWidth (16),
        .FifoDepthLog2(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .TxD_start   (TxD_start),
        .TxD_data    (TxD_data),
        .TxD_full    (TxD_full),
        .TxD_overflow(TxD_overflow),
        .TxD_busy    (TxD_busy),
        .TxD_level   (TxD_level),
        .TxD         (TxD)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line receiver: first low sample is the start bit; data sampled near mid-bit at ~10 clk/bit.
    initial begin : rx_mon
        logic [7:0] b;
        int t_stop;
        t_stop = -1000;
        b = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && TxD === 1'b0) begin
                rx_gap_q.push_back(cyc - t_stop);
                for (int k = 0; k < 8; k++) begin
                    repeat (k == 0 ? 16 : 10) @(posedge clk);
                    #1;
                    b[k] = TxD;
                end
                repeat (10) @(posedge clk);
                #1;
                rx_q.push_back(b);
                rx_stop_q.push_back(TxD);
                t_stop = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic clear_rx();
        rx_q.delete();
        rx_stop_q.delete();
        rx_gap_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_idle(input int budget, input string name);
        for (int i = 0; i < budget && TxD_busy; i++) tick();
        chk(name, int'(TxD_busy), 0);
    endtask

    task automatic chk_rx(input string name);
        chk({name, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            chk($sformatf("%s_byte%0d", name, i), int'(rx_q[i]), int'(exp_q[i]));
            chk($sformatf("%s_stop%0d", name, i), int'(rx_stop_q[i]), 1);
        end
    endtask

    task automatic wr(input logic [7:0] d);
        TxD_start = 1'b1;
        TxD_data  = d;
        tick();
        TxD_start = 1'b0;
    endtask

    initial begin : main
        int prev, last, ntr, bad, busy_t, lows, n_sent, n_ovf, n_bad;

        vecs[0] = '{1'b1, 8'h11, 1, 0, 1, 0, 1};
        vecs[1] = '{1'b1, 8'h22, 1, 0, 1, 0, 0};
        vecs[2] = '{1'b1, 8'h33, 2, 0, 1, 0, 0};
        vecs[3] = '{1'b1, 8'h44, 3, 0, 1, 0, 0};
        vecs[4] = '{1'b1, 8'h55, 4, 1, 1, 0, 0};
        vecs[5] = '{1'b1, 8'h66, 4, 1, 1, 1, 0};
        vecs[6] = '{1'b0, 8'h00, 4, 1, 1, 0, 0};

        // Reset state
        repeat (3) tick();
        chk("rst_txd", int'(TxD), 1);
        chk("rst_level", int'(TxD_level), 0);
        chk("rst_full", int'(TxD_full), 0);
        chk("rst_busy", int'(TxD_busy), 0);
        chk("rst_ovf", int'(TxD_overflow), 0);
        rst = 1'b0;
        tick();

        // Single 0x55: latency, per-bit timing, busy release
        clear_rx();
        exp_q.push_back(8'h55);
        wr(8'h55);
        chk("t1_txd_k", int'(TxD), 1);
        chk("t1_level_k", int'(TxD_level), 1);
        chk("t1_busy_k", int'(TxD_busy), 1);
        tick();
        chk("t1_txd_k1", int'(TxD), 0);
        chk("t1_level_k1", int'(TxD_level), 0);
        prev = 0; last = 0; ntr = 0; bad = 0; busy_t = 0;
        for (int t = 1; t <= 150; t++) begin
            tick();
            if (int'(TxD) != prev) begin
                ntr++;
                if (t - last < 9 || t - last > 11) bad++;
                last = t;
                prev = int'(TxD);
            end
            if (!TxD_busy) begin
                busy_t = t;
                break;
            end
        end
        chk("t1_transitions", ntr, 9);
        chk("t1_bad_bit_len", bad, 0);
        chk("t1_stop_len_ok", int'(busy_t - last >= 9 && busy_t - last <= 11), 1);
        chk("t1_txd_end", int'(TxD), 1);
        chk("t1_level_end", int'(TxD_level), 0);
        repeat (5) tick();
        chk_rx("t1");

        // Three consecutive writes: back-to-back frames, one stop bit each
        clear_rx();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hA5);
        wr(8'h00);
        wr(8'hFF);
        wr(8'hA5);
        wait_idle(600, "t2_idle");
        repeat (5) tick();
        chk_rx("t2");
        if (rx_gap_q.size() >= 3) begin
            chk("t2_gap1_le6", int'(rx_gap_q[1] <= 6), 1);
            chk("t2_gap2_le6", int'(rx_gap_q[2] <= 6), 1);
        end else begin
            chk("t2_gap_frames", rx_gap_q.size(), 3);
        end

        // Six writes into a depth-4 FIFO from idle
        clear_rx();
        for (int i = 0; i < 7; i++) begin
            TxD_start = vecs[i].start;
            TxD_data  = vecs[i].data;
            tick();
            chk($sformatf("t3_v%0d_level", i), int'(TxD_level), vecs[i].level);
            chk($sformatf("t3_v%0d_full", i), int'(TxD_full), vecs[i].full);
            chk($sformatf("t3_v%0d_busy", i), int'(TxD_busy), vecs[i].busy);
            chk($sformatf("t3_v%0d_ovf", i), int'(TxD_overflow), vecs[i].ovf);
            chk($sformatf("t3_v%0d_txd", i), int'(TxD), vecs[i].txd);
        end
        TxD_start = 1'b0;
        for (int i = 0; i < 5; i++) exp_q.push_back(vecs[i].data);
        wait_idle(800, "t3_idle");
        repeat (5) tick();
        chk_rx("t3");

        // Write while full in the same cycle as the STOP-tick pop
        clear_rx();
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'h81);
        exp_q.push_back(8'h7E);
        exp_q.push_back(8'h5A);
        for (int i = 0; i < 5; i++) wr(exp_q[i]);
        repeat (97) tick();
        chk("t4_level_pre", int'(TxD_level), 4);
        chk("t4_full_pre", int'(TxD_full), 1);
        chk("t4_txd_pre", int'(TxD), 1);
        wr(8'hEE);
        chk("t4_level_post", int'(TxD_level), 3);
        chk("t4_ovf_post", int'(TxD_overflow), 1);
        chk("t4_full_post", int'(TxD_full), 0);
        chk("t4_txd_post", int'(TxD), 0);
        wait_idle(700, "t4_idle");
        repeat (5) tick();
        chk_rx("t4");

        // Reset during B3 with two bytes queued
        clear_rx();
        wr(8'hF7);
        wr(8'h12);
        wr(8'h34);
        repeat (44) tick();
        chk("t5_txd_b3", int'(TxD), 0);
        chk("t5_level_b3", int'(TxD_level), 2);
        rst = 1'b1;
        tick();
        chk("t5_txd_rst", int'(TxD), 1);
        chk("t5_level_rst", int'(TxD_level), 0);
        chk("t5_busy_rst", int'(TxD_busy), 0);
        chk("t5_full_rst", int'(TxD_full), 0);
        rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (TxD !== 1'b1) lows++;
        end
        chk("t5_no_frames", lows, 0);
        chk("t5_busy_after", int'(TxD_busy), 0);

        // 256 random bytes through the line receiver
        clear_rx();
        n_sent = 0;
        n_ovf = 0;
        for (int c = 0; c < 40000 && n_sent < 256; c++) begin
            if (!TxD_full) begin
                TxD_start = 1'b1;
                TxD_data  = 8'($urandom);
                exp_q.push_back(TxD_data);
                n_sent++;
            end else begin
                TxD_start = 1'b0;
            end
            tick();
            if (TxD_overflow) n_ovf++;
        end
        TxD_start = 1'b0;
        chk("t6_sent", n_sent, 256);
        chk("t6_overflows", n_ovf, 0);
        wait_idle(1200, "t6_idle");
        repeat (5) tick();
        chk("t6_count", rx_q.size(), 256);
        n_bad = 0;
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            if (rx_q[i] !== exp_q[i] || rx_stop_q[i] !== 1'b1) n_bad++;
        end
        chk("t6_data_errors", n_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
